// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM driven by command pulses, counting
// time-base ticks into a cs/sec/min chain with lap capture and sticky overflow.
module stopwatch_ctrl #(
  parameter int CS_MOD  = 100,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_run,
  output logic [6:0] o_cs,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_lap_valid,
  output logic [6:0] o_lap_cs,
  output logic [5:0] o_lap_sec,
  output logic [5:0] o_lap_min,
  output logic       o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [6:0] CS_LAST  = 7'(CS_MOD - 1);
  localparam logic [5:0] SEC_LAST = 6'(SEC_MOD - 1);
  localparam logic [5:0] MIN_LAST = 6'(MIN_MOD - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_run;
  logic [6:0] r_cs;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic       r_lap_valid;
  logic [6:0] r_lap_cs;
  logic [5:0] r_lap_sec;
  logic [5:0] r_lap_min;
  logic       r_overflow;

  logic       w_count;
  logic       w_clear;
  logic       w_lap;
  logic       w_cs_wrap;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic [6:0] w_cs_nxt;
  logic [5:0] w_sec_nxt;
  logic [5:0] w_min_nxt;
  logic       w_ovf_set;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; clear outranks start_stop outside RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_clear) begin
          w_next = S_IDLE;
        end else if (i_start_stop) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_start_stop) begin
          w_next = S_PAUSE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_PAUSE: begin
        if (i_clear) begin
          w_next = S_IDLE;
        end else if (i_start_stop) begin
          w_next = S_RUN;
        end else begin
          w_next = S_PAUSE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output decode: qualifiers use the current state, so a tick with stop counts
  always_comb begin
    w_count    = (r_state == S_RUN) && i_tick;
    w_lap      = (r_state == S_RUN) && i_lap;
    w_clear    = (r_state != S_RUN) && i_clear;
    w_cs_wrap  = (r_cs == CS_LAST);
    w_sec_wrap = (r_sec == SEC_LAST);
    w_min_wrap = (r_min == MIN_LAST);
    w_cs_nxt   = w_cs_wrap ? 7'd0 : (r_cs + 7'd1);
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_ovf_set  = 1'b0;
    if (w_cs_wrap) begin
      w_sec_nxt = w_sec_wrap ? 6'd0 : (r_sec + 6'd1);
      if (w_sec_wrap) begin
        w_min_nxt = w_min_wrap ? 6'd0 : (r_min + 6'd1);
        w_ovf_set = w_min_wrap;
      end else begin
        w_min_nxt = r_min;
      end
    end else begin
      w_sec_nxt = r_sec;
    end
  end

  // Registered datapath: counts, lap capture, overflow and run flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_run       <= 1'b0;
      r_cs        <= 7'd0;
      r_sec       <= 6'd0;
      r_min       <= 6'd0;
      r_lap_valid <= 1'b0;
      r_lap_cs    <= 7'd0;
      r_lap_sec   <= 6'd0;
      r_lap_min   <= 6'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_run       <= (w_next == S_RUN);
      r_lap_valid <= w_lap;
      if (w_clear) begin
        r_cs       <= 7'd0;
        r_sec      <= 6'd0;
        r_min      <= 6'd0;
        r_lap_cs   <= 7'd0;
        r_lap_sec  <= 6'd0;
        r_lap_min  <= 6'd0;
        r_overflow <= 1'b0;
      end else begin
        if (w_lap) begin
          r_lap_cs  <= r_cs;
          r_lap_sec <= r_sec;
          r_lap_min <= r_min;
        end
        if (w_count) begin
          r_cs  <= w_cs_nxt;
          r_sec <= w_sec_nxt;
          r_min <= w_min_nxt;
          if (w_ovf_set) begin
            r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign o_run       = r_run;
  assign o_cs        = r_cs;
  assign o_sec       = r_sec;
  assign o_min       = r_min;
  assign o_lap_valid = r_lap_valid;
  assign o_lap_cs    = r_lap_cs;
  assign o_lap_sec   = r_lap_sec;
  assign o_lap_min   = r_lap_min;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: default-size instance for control/lap
// behaviour, small-modulus instance to reach the minute wrap and overflow.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       i_reset = 1'b1, i_tick = 1'b0, i_start_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0;
  logic       o_run, o_lap_valid, o_overflow;
  logic [6:0] o_cs, o_lap_cs;
  logic [5:0] o_sec, o_min, o_lap_sec, o_lap_min;

  logic       s_reset = 1'b1, s_tick = 1'b0, s_start_stop = 1'b0, s_clear = 1'b0, s_lap = 1'b0;
  logic       s_run, s_lap_valid, s_overflow;
  logic [6:0] s_cs, s_lap_cs;
  logic [5:0] s_sec, s_min, s_lap_sec, s_lap_min;

  stopwatch_ctrl u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .i_lap(i_lap), .o_run(o_run), .o_cs(o_cs), .o_sec(o_sec),
    .o_min(o_min), .o_lap_valid(o_lap_valid), .o_lap_cs(o_lap_cs),
    .o_lap_sec(o_lap_sec), .o_lap_min(o_lap_min), .o_overflow(o_overflow)
  );

  stopwatch_ctrl #(.CS_MOD(4), .SEC_MOD(3), .MIN_MOD(2)) u_small (
    .i_clk(clk), .i_reset(s_reset), .i_tick(s_tick), .i_start_stop(s_start_stop),
    .i_clear(s_clear), .i_lap(s_lap), .o_run(s_run), .o_cs(s_cs), .o_sec(s_sec),
    .o_min(s_min), .o_lap_valid(s_lap_valid), .o_lap_cs(s_lap_cs),
    .o_lap_sec(s_lap_sec), .o_lap_min(s_lap_min), .o_overflow(s_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int run, input int cs, input int sec, input int mn);
    chk({tag, ".run"}, 32'(o_run), 32'(run));
    chk({tag, ".cs"},  32'(o_cs),  32'(cs));
    chk({tag, ".sec"}, 32'(o_sec), 32'(sec));
    chk({tag, ".min"}, 32'(o_min), 32'(mn));
  endtask

  task automatic chk_lap(input string tag, input int vld, input int cs, input int sec, input int mn);
    chk({tag, ".lvld"}, 32'(o_lap_valid), 32'(vld));
    chk({tag, ".lcs"},  32'(o_lap_cs),    32'(cs));
    chk({tag, ".lsec"}, 32'(o_lap_sec),   32'(sec));
    chk({tag, ".lmin"}, 32'(o_lap_min),   32'(mn));
  endtask

  // Drive one cycle of inputs on the default instance; outputs are sampled afterwards at negedge
  task automatic cyc(input logic ss, input logic clr, input logic lp, input logic tk);
    i_start_stop = ss; i_clear = clr; i_lap = lp; i_tick = tk;
    @(negedge clk);
    i_start_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0; i_tick = 1'b0;
  endtask

  task automatic scyc(input logic ss, input logic clr, input logic tk);
    s_start_stop = ss; s_clear = clr; s_tick = tk;
    @(negedge clk);
    s_start_stop = 1'b0; s_clear = 1'b0; s_tick = 1'b0;
  endtask

  initial begin
    // Reset for two cycles with ticks present, then ticks without a start
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    i_reset = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("idle", 0, 0, 0, 0);
    chk_lap("idle", 0, 0, 0, 0);
    chk("idle.ovf", 32'(o_overflow), 32'd0);

    // Basic count, one tick every four clocks
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("start", 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("lat1", 1, 1, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (249) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_cnt("t250", 1, 50, 2, 0);

    // Stop, clear, restart and count to 0/0/37
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("stop", 0, 50, 2, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt("clr_pause", 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (37) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("t37", 1, 37, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt("clr_run_ign", 1, 37, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_cnt("stop_tick", 0, 38, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("pause_hold", 0, 38, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_lap("lap_pause", 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_cnt("clr_start", 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("clr_start_idle", 0, 0, 0, 0);

    // Back-to-back start_stop: IDLE->RUN->PAUSE, then start with tick is not counted
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b.run1", 32'(o_run), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b.run0", 32'(o_run), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("b2b_pause", 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_cnt("start_tick", 1, 0, 0, 0);

    // Lap coincident with the tick that carries 1.99 into 2.00
    repeat (199) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("t199", 1, 99, 1, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt("lap_tick", 1, 0, 2, 0);
    chk_lap("lap_tick", 1, 99, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_lap("lap_after", 0, 99, 1, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_lap("lap_stop", 1, 0, 2, 0);
    chk("lap_stop.run", 32'(o_run), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_lap("lap_in_pause", 0, 0, 2, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt("clr2", 0, 0, 0, 0);
    chk_lap("clr2", 0, 0, 0, 0);

    // Reset mid-RUN at 0/3/17 with a tick present
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (317) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("t317", 1, 17, 3, 0);
    i_reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    i_reset = 1'b0;
    chk_cnt("rst_run", 0, 0, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk_cnt("rst_after", 0, 0, 0, 0);

    // Small-modulus instance: 4 x 3 x 2 = 24 ticks per full wrap
    s_reset = 1'b0;
    scyc(1'b1, 1'b0, 1'b0);
    chk("s.run", 32'(s_run), 32'd1);
    repeat (23) scyc(1'b0, 1'b0, 1'b1);
    chk("s23.cs", 32'(s_cs), 32'd3);
    chk("s23.sec", 32'(s_sec), 32'd2);
    chk("s23.min", 32'(s_min), 32'd1);
    chk("s23.ovf", 32'(s_overflow), 32'd0);
    scyc(1'b0, 1'b0, 1'b1);
    chk("s24.cs", 32'(s_cs), 32'd0);
    chk("s24.sec", 32'(s_sec), 32'd0);
    chk("s24.min", 32'(s_min), 32'd0);
    chk("s24.ovf", 32'(s_overflow), 32'd1);
    scyc(1'b0, 1'b0, 1'b1);
    chk("s25.cs", 32'(s_cs), 32'd1);
    chk("s25.ovf", 32'(s_overflow), 32'd1);
    scyc(1'b1, 1'b0, 1'b0);
    chk("s_pause.ovf", 32'(s_overflow), 32'd1);
    scyc(1'b0, 1'b1, 1'b0);
    chk("s_clr.ovf", 32'(s_overflow), 32'd0);
    chk("s_clr.cs", 32'(s_cs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
